// File: rtl/store_unit.sv
// Store buffer: encodes SB/SH/SW into word address, lane-replicated data and byte strobe; drains in order. Optional trap: STORE_MISALIGN_TRAP_EN.
// Latency: a store accepted in cycle N is presented to memory in cycle N+1; head outputs are registered state.
// Backpressure: store_ready_o = !full with no path from mem_ready_i; head holds while mem_valid_o & !mem_ready_i.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_vld & ~full;
  assign pop    = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr];

  // Storage is reset too so the head reads as zero while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module store_unit #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        store_valid_i,
  output logic        store_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        busy_o,
  output logic        misalign_o
);
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  entry_t enc;
  entry_t head;
  logic   full;
  logic   empty;
  logic   reject;

  always_comb begin
    enc.waddr = addr_i[31:2];
    enc.wdata = data_i;
    enc.wstrb = 4'b1111;
    case (funct3_i)
      3'b000: begin
        enc.wdata = {4{data_i[7:0]}};
        enc.wstrb = 4'b0001 << addr_i[1:0];
      end
      3'b001: begin
        enc.wdata = {2{data_i[15:0]}};
        enc.wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = ((funct3_i == 3'b001) & addr_i[0]) |
                      ((funct3_i == 3'b010) & (addr_i[1:0] != 2'b00));
  assign reject     = misaligned;
  assign misalign_o = misalign_q;

  // Rejected stores still complete the handshake; only the pulse records them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misalign_q <= 1'b0;
    else         misalign_q <= store_valid_i & store_ready_o & misaligned;
  end
`else
  assign reject     = 1'b0;
  assign misalign_o = 1'b0;
`endif

  fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_vld (store_valid_i & ~reject),
    .wr_dat (enc),
    .rd_rdy (mem_ready_i),
    .rd_dat (head),
    .full   (full),
    .empty  (empty)
  );

  assign store_ready_o = ~full;
  assign mem_valid_o   = ~empty;
  assign busy_o        = ~empty;
  assign mem_addr_o    = {head.waddr, 2'b00};
  assign mem_wdata_o   = head.wdata;
  assign mem_wstrb_o   = head.wstrb;
endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: expected memory requests queued at handshake time, compared as they drain.
module tb_store_unit;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        store_valid_i;
  logic        store_ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        busy_o;
  logic        misalign_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  store_unit #(.DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .store_valid_i (store_valid_i),
    .store_ready_o (store_ready_o),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .mem_valid_o   (mem_valid_o),
    .mem_ready_i   (mem_ready_i),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wstrb_o   (mem_wstrb_o),
    .busy_o        (busy_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t enc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a & 32'hFFFF_FFFC;
    if (f == 3'b000) begin
      e.wstrb = 4'b0000;
      e.wstrb[a[1:0]] = 1'b1;
      e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
    end else if (f == 3'b001) begin
      e.wstrb = a[1] ? 4'hC : 4'h3;
      e.wdata = {d[15:0], d[15:0]};
    end else begin
      e.wstrb = 4'hF;
      e.wdata = d;
    end
    return e;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    store_valid_i = 1'b1;
    funct3_i      = f;
    addr_i        = a;
    data_i        = d;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; store_valid_i = 1'b0; mem_ready_i = 1'b0;
    funct3_i = 3'b0; addr_i = '0; data_i = '0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({store_ready_o, mem_valid_o, busy_o, misalign_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags got rdy/vld/busy/mis=%b exp=1000", {store_ready_o, mem_valid_o, busy_o, misalign_o});
    end
    n_cmp++;
    if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 68'h0) begin
      n_err++;
      $display("FAIL reset_head got %h/%h/%b exp zero", mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_sb_single();
    mem_ready_i = 1'b1;
    drive(3'b000, 32'h1003, 32'h0000_00A5);
    @(posedge clk_i); #1 store_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (mem_valid_o !== 1'b1) begin n_err++; $display("FAIL sb_valid got=%b exp=1", mem_valid_o); end
    n_cmp++;
    if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {32'h1000, 32'hA5A5A5A5, 4'b1000}) begin
      n_err++;
      $display("FAIL sb_head got %h/%h/%b exp 00001000/a5a5a5a5/1000", mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL sb_busy_after got=%b exp=0", busy_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_full_stall();
    mem_ready_i = 1'b0;
    drive(3'b001, 32'h2002, 32'hFFFF_1234);
    @(posedge clk_i); #1 drive(3'b010, 32'h2004, 32'hDEAD_BEEF);
    @(posedge clk_i); #1 store_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({store_ready_o, mem_valid_o, busy_o} !== 3'b011) begin
        n_err++;
        $display("FAIL full_flags cyc%0d got rdy/vld/busy=%b exp=011", c, {store_ready_o, mem_valid_o, busy_o});
      end
      n_cmp++;
      if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {32'h2000, 32'h12341234, 4'b1100}) begin
        n_err++;
        $display("FAIL full_head_hold cyc%0d got %h/%h/%b exp 00002000/12341234/1100", c, mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end
      @(posedge clk_i); #1;
    end
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {1'b1, 32'h2000, 32'h12341234, 4'b1100}) begin
      n_err++;
      $display("FAIL drain_first got %b %h/%h/%b exp 1 00002000/12341234/1100", mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {1'b1, 32'h2004, 32'hDEADBEEF, 4'b1111}) begin
      n_err++;
      $display("FAIL drain_second got %b %h/%h/%b exp 1 00002004/deadbeef/1111", mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty got=%b exp=0", mem_valid_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f_tab [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b010, 3'b000};
    logic [31:0] a_tab [6] = '{32'h4002, 32'h4006, 32'h4009, 32'h400A, 32'h4010, 32'h4015};
    logic [31:0] d_tab [6] = '{32'h1111_2233, 32'hAAAA_5678, 32'h0BAD_F00D, 32'h7654_3210, 32'hFACE_B00C, 32'h0000_00E7};
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    exp_t e;
    mem_ready_i = 1'b0;
    drive(3'b010, 32'h4100, 32'h0101_0101);
    exp_q.push_back(enc(3'b010, 32'h4100, 32'h0101_0101));
    @(posedge clk_i); #1 drive(3'b001, 32'h4104, 32'h0000_BEEF);
    exp_q.push_back(enc(3'b001, 32'h4104, 32'h0000_BEEF));
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    drive(f_tab[0], a_tab[0], d_tab[0]);
    while (got < 8 && cyc < 40) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        n_cmp++;
        if (store_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full_stall got rdy=%b exp=0", store_ready_o); end
      end else if (cyc == 1) begin
        n_cmp++;
        if (store_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_return got rdy=%b exp=1", store_ready_o); end
      end
      if (mem_valid_o && mem_ready_i) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra got %h/%h/%b exp no request", mem_addr_o, mem_wdata_o, mem_wstrb_o);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr_o, mem_wdata_o, mem_wstrb_o} !== e) begin
            n_err++;
            $display("FAIL b2b_entry%0d got %h/%h/%b exp %h/%h/%b", got, mem_addr_o, mem_wdata_o, mem_wstrb_o, e.addr, e.wdata, e.wstrb);
          end
        end
      end
      if (store_valid_i && store_ready_o) begin
        exp_q.push_back(enc(funct3_i, addr_i, data_i));
        sent++;
      end
      @(posedge clk_i); #1;
      if (sent < 6) drive(f_tab[sent], a_tab[sent], d_tab[sent]);
      else store_valid_i = 1'b0;
      cyc++;
    end
    n_cmp++;
    if (got != 8 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count got drained=%0d left=%0d exp drained=8 left=0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    mem_ready_i = 1'b0;
    drive(3'b010, 32'h6000, 32'h1234_5678);
    @(posedge clk_i); #1 drive(3'b010, 32'h6004, 32'h9ABC_DEF0);
    @(posedge clk_i); #1 store_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_valid_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h6000, 32'h12345678}) begin
      n_err++;
      $display("FAIL rst_pre_head got %b %h/%h exp 1 00006000/12345678", mem_valid_o, mem_addr_o, mem_wdata_o);
    end
    @(posedge clk_i); #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({mem_valid_o, busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_async got vld/busy=%b exp=00", {mem_valid_o, busy_o});
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({mem_valid_o, busy_o, store_ready_o} !== 3'b001) begin
        n_err++;
        $display("FAIL rst_stale cyc%0d got vld/busy/rdy=%b exp=001", c, {mem_valid_o, busy_o, store_ready_o});
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_misalign();
    mem_ready_i = 1'b1;
    drive(3'b010, 32'h3001, 32'hCAFE_F00D);
    @(negedge clk_i);
    n_cmp++;
    if (store_ready_o !== 1'b1) begin n_err++; $display("FAIL mis_ready got=%b exp=1", store_ready_o); end
    @(posedge clk_i); #1 store_valid_i = 1'b0;
    @(negedge clk_i);
`ifdef STORE_MISALIGN_TRAP_EN
    n_cmp++;
    if ({misalign_o, mem_valid_o} !== 2'b10) begin
      n_err++;
      $display("FAIL mis_trap got mis/vld=%b exp=10", {misalign_o, mem_valid_o});
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if ({misalign_o, mem_valid_o} !== 2'b00) begin
      n_err++;
      $display("FAIL mis_pulse_end got mis/vld=%b exp=00", {misalign_o, mem_valid_o});
    end
`else
    n_cmp++;
    if ({misalign_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {2'b01, 32'h3000, 32'hCAFEF00D, 4'b1111}) begin
      n_err++;
      $display("FAIL mis_align_down got mis=%b vld=%b %h/%h/%b exp 0 1 00003000/cafef00d/1111",
               misalign_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if ({misalign_o, busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL mis_drained got mis/busy=%b exp=00", {misalign_o, busy_o});
    end
`endif
    @(posedge clk_i); #1;
  endtask

  task automatic test_sb_stream();
    logic [3:0]  strb_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] wd_tab   [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0] d_tab    [4] = '{32'hFFFF_FF11, 32'h0000_0022, 32'h1234_5633, 32'h0000_0044};
    mem_ready_i = 1'b1;
    drive(3'b000, 32'h5000, d_tab[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (i < 3) drive(3'b000, 32'h5000 + 32'(i + 1), d_tab[i + 1]);
      else store_valid_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({store_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== {2'b11, 32'h5000, wd_tab[i], strb_tab[i]}) begin
        n_err++;
        $display("FAIL stream%0d got rdy=%b vld=%b %h/%h/%b exp 1 1 00005000/%h/%b",
                 i, store_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, wd_tab[i], strb_tab[i]);
      end
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL stream_end busy got=%b exp=0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_sb_single();
    test_full_stall();
    test_back_to_back();
    test_reset_mid_drain();
    test_misalign();
    test_sb_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
